// File: rtl/sha256_msg_padder_if.sv
// Load-side bus of the SHA-256 message padder: producer words in, 16-word block bursts out.
// slave = padder side, master = producer/core side.
interface sha256_msg_padder_if;
  logic        iStart;
  logic        iValid;
  logic [31:0] iWord;
  logic        iLast;
  logic [2:0]  iLastBytes;
  logic        oReady;
  logic        iCoreDone;
  logic        oDataValid;
  logic [31:0] oData;
  logic [3:0]  oWordIdx;
  logic        oBlockStart;
  logic        oFirstBlock;
  logic        oLastBlock;
  logic        oMsgDone;
  logic        oBusy;

  modport slave (
    input  iStart, iValid, iWord, iLast, iLastBytes, iCoreDone,
    output oReady, oDataValid, oData, oWordIdx, oBlockStart,
           oFirstBlock, oLastBlock, oMsgDone, oBusy
  );

  modport master (
    output iStart, iValid, iWord, iLast, iLastBytes, iCoreDone,
    input  oReady, oDataValid, oData, oWordIdx, oBlockStart,
           oFirstBlock, oLastBlock, oMsgDone, oBusy
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: buffers one 512-bit block, appends 0x80 marker, zeros and 64-bit length,
// and bursts each block to the core. Optional macro SHA_PAD_BSWAP_EN: little-endian producer words.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input logic           iClk,
  input logic           iReset_n,
  sha256_msg_padder_if.slave bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WR_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_EMIT,
    S_WAIT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_buf [NWORDS];
  logic [WR_W-1:0]   r_wr_idx, w_wr_idx_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic              r_mark_pend, w_mark_pend_nxt;
  logic              r_len_ok, w_len_ok_nxt;
  logic              r_msg_end, w_msg_end_nxt;
  logic              r_first, w_first_nxt;
  logic              w_msg_done_nxt;

  logic              w_we;
  logic [IDX_W-1:0]  w_widx;
  logic [WORD_W-1:0] w_wdata;

  logic              r_ready;
  logic              r_dvalid;
  logic [WORD_W-1:0] r_data;
  logic [IDX_W-1:0]  r_widx;
  logic              r_bstart;
  logic              r_first_o;
  logic              r_last_o;
  logic              r_msg_done;
  logic              r_busy;

  logic [WORD_W-1:0] w_word;
  logic [2:0]        w_lb;
  logic              w_accept;
  logic [63:0]       w_len64;
  logic [WORD_W-1:0] w_marked;
  logic              w_emit_nxt;
  logic              w_hold_nxt;

`ifdef SHA_PAD_BSWAP_EN
  assign w_word = {bus.iWord[7:0], bus.iWord[15:8], bus.iWord[23:16], bus.iWord[31:24]};
`else
  assign w_word = bus.iWord;
`endif

  assign w_lb     = (bus.iLastBytes > 3'd4) ? 3'd4 : bus.iLastBytes;
  assign w_accept = bus.iValid & r_ready;
  assign w_len64  = 64'(r_len);

  // Keep the valid leading bytes of the last word and drop the marker right behind them.
  always_comb begin
    w_marked = 32'h8000_0000;
    unique case (w_lb)
      3'd1:    w_marked = {w_word[31:24], 24'h80_0000};
      3'd2:    w_marked = {w_word[31:16], 16'h8000};
      3'd3:    w_marked = {w_word[31:8],  8'h80};
      default: w_marked = 32'h8000_0000;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_idx_nxt    = r_wr_idx;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_mark_pend_nxt = r_mark_pend;
    w_len_ok_nxt    = r_len_ok;
    w_msg_end_nxt   = r_msg_end;
    w_first_nxt     = r_first;
    w_msg_done_nxt  = 1'b0;
    w_we            = 1'b0;
    w_widx          = r_wr_idx[IDX_W-1:0];
    w_wdata         = '0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.iStart) begin
          w_state_nxt     = S_FILL;
          w_wr_idx_nxt    = '0;
          w_len_nxt       = '0;
          w_mark_pend_nxt = 1'b0;
          w_len_ok_nxt    = 1'b0;
          w_msg_end_nxt   = 1'b0;
          w_first_nxt     = 1'b1;
        end
      end

      S_FILL: begin
        if (w_accept) begin
          w_we         = 1'b1;
          w_wr_idx_nxt = r_wr_idx + WR_W'(1);
          if (bus.iLast) begin
            w_msg_end_nxt = 1'b1;
            w_len_nxt     = r_len + LEN_W'({w_lb, 3'b000});
            // len_ok: marker lands at index <= 13, so the length fits in this block
            if (w_lb == 3'd4) begin
              w_wdata         = w_word;
              w_mark_pend_nxt = 1'b1;
              w_len_ok_nxt    = (r_wr_idx < WR_W'(13));
            end else begin
              w_wdata      = w_marked;
              w_len_ok_nxt = (r_wr_idx < WR_W'(14));
            end
            w_state_nxt = (r_wr_idx == WR_W'(15)) ? S_EMIT : S_PAD;
          end else begin
            w_wdata   = w_word;
            w_len_nxt = r_len + LEN_W'(32);
            if (r_wr_idx == WR_W'(15)) w_state_nxt = S_EMIT;
          end
          if (w_state_nxt == S_EMIT) w_cnt_nxt = '0;
        end
      end

      S_PAD: begin
        w_we         = 1'b1;
        w_wr_idx_nxt = r_wr_idx + WR_W'(1);
        if (r_mark_pend) begin
          w_wdata         = 32'h8000_0000;
          w_mark_pend_nxt = 1'b0;
        end else if (r_len_ok && (r_wr_idx == WR_W'(14))) begin
          w_wdata = w_len64[63:32];
        end else if (r_len_ok && (r_wr_idx == WR_W'(15))) begin
          w_wdata = w_len64[31:0];
        end
        if (r_wr_idx == WR_W'(15)) begin
          w_state_nxt = S_EMIT;
          w_cnt_nxt   = '0;
        end
      end

      S_EMIT: begin
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(15)) w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (bus.iCoreDone) begin
          w_first_nxt  = 1'b0;
          w_wr_idx_nxt = '0;
          if (r_len_ok) begin
            w_state_nxt    = S_IDLE;
            w_msg_done_nxt = 1'b1;
          end else if (r_msg_end) begin
            // message data exhausted: next block is marker/zeros plus length only
            w_state_nxt  = S_PAD;
            w_len_ok_nxt = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_emit_nxt = (w_state_nxt == S_EMIT);
  assign w_hold_nxt = w_emit_nxt || (w_state_nxt == S_WAIT);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state     <= S_IDLE;
      r_wr_idx    <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_mark_pend <= 1'b0;
      r_len_ok    <= 1'b0;
      r_msg_end   <= 1'b0;
      r_first     <= 1'b0;
      for (int i = 0; i < NWORDS; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_mark_pend <= w_mark_pend_nxt;
      r_len_ok    <= w_len_ok_nxt;
      r_msg_end   <= w_msg_end_nxt;
      r_first     <= w_first_nxt;
      if (w_we) r_buf[w_widx] <= w_wdata;
    end
  end

  // Outputs registered from next-state values so they line up with the state they describe.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_ready    <= 1'b0;
      r_dvalid   <= 1'b0;
      r_data     <= '0;
      r_widx     <= '0;
      r_bstart   <= 1'b0;
      r_first_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_msg_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ready    <= (w_state_nxt == S_FILL);
      r_dvalid   <= w_emit_nxt;
      r_data     <= w_emit_nxt ? r_buf[w_cnt_nxt] : '0;
      r_widx     <= w_emit_nxt ? w_cnt_nxt : '0;
      r_bstart   <= w_emit_nxt && (w_cnt_nxt == '0);
      r_first_o  <= w_hold_nxt && w_first_nxt;
      r_last_o   <= w_hold_nxt && w_len_ok_nxt;
      r_msg_done <= w_msg_done_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.oReady      = r_ready;
  assign bus.oDataValid  = r_dvalid;
  assign bus.oData       = r_data;
  assign bus.oWordIdx    = r_widx;
  assign bus.oBlockStart = r_bstart;
  assign bus.oFirstBlock = r_first_o;
  assign bus.oLastBlock  = r_last_o;
  assign bus.oMsgDone    = r_msg_done;
  assign bus.oBusy       = r_busy;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of messages with hand-computed padded blocks,
// plus reset-state and mid-burst reset sequences.
module tb_sha256_msg_padder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus.slave)
  );

  localparam logic [31:0] P = 32'h6161_6161;

  typedef struct {
    int          nw;        // words driven, last one carries iLast
    logic [2:0]  lb;        // iLastBytes
    logic [31:0] last;      // last word as first-byte-in-[31:24]
    int          mark_idx;  // global index of the marker word
    logic [31:0] mark_val;
    int          nblk;
    logic [31:0] len;       // low length word (high word is zero here)
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] drv(input logic [31:0] w);
`ifdef SHA_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] expw(input vec_t v, input int g);
    if (g == v.mark_idx)        return v.mark_val;
    if (g < v.nw - 1)           return P;
    if (g == v.nw - 1)          return v.last;
    if (g == 16 * v.nblk - 1)   return v.len;
    return 32'h0;
  endfunction

  task automatic drive_msg(input vec_t v);
    int n;
    for (int k = 0; k < v.nw; k++) begin
      bus.iValid     = 1'b1;
      bus.iWord      = drv((k == v.nw - 1) ? v.last : P);
      bus.iLast      = (k == v.nw - 1);
      bus.iLastBytes = (k == v.nw - 1) ? v.lb : 3'd0;
      n = 0;
      while (!bus.oReady && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout word %0d", k);
        break;
      end
      @(negedge clk);
    end
    bus.iValid = 1'b0;
    bus.iLast  = 1'b0;
  endtask

  task automatic check_msg(input vec_t v, input string tag);
    int n;
    for (int b = 0; b < v.nblk; b++) begin
      n = 0;
      while (!bus.oDataValid && n < 600) begin
        @(negedge clk);
        n++;
      end
      if (n >= 600) begin
        checks++;
        errors++;
        $display("FAIL %s emit_timeout block %0d", tag, b);
        return;
      end
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("%s b%0d w%0d data", tag, b, i), 64'(bus.oData), 64'(expw(v, 16 * b + i)));
        chk($sformatf("%s b%0d w%0d idx", tag, b, i), 64'(bus.oWordIdx), 64'(i));
        chk($sformatf("%s b%0d w%0d flags", tag, b, i),
            64'({bus.oDataValid, bus.oBlockStart, bus.oFirstBlock, bus.oLastBlock, bus.oReady}),
            64'({1'b1, i == 0, b == 0, b == v.nblk - 1, 1'b0}));
        // a done pulse mid-burst must be ignored
        bus.iCoreDone = (i == 5);
        @(negedge clk);
      end
      bus.iCoreDone = 1'b0;
      chk($sformatf("%s b%0d wait", tag, b),
          64'({bus.oDataValid, bus.oBusy, bus.oReady, bus.oFirstBlock, bus.oLastBlock, bus.oMsgDone}),
          64'({1'b0, 1'b1, 1'b0, b == 0, b == v.nblk - 1, 1'b0}));
      repeat (3) @(negedge clk);
      chk($sformatf("%s b%0d still_wait", tag, b), 64'({bus.oDataValid, bus.oBusy}), 64'(2'b01));
      bus.iCoreDone = 1'b1;
      @(negedge clk);
      bus.iCoreDone = 1'b0;
      chk($sformatf("%s b%0d done", tag, b), 64'({bus.oMsgDone, bus.oBusy}),
          64'({b == v.nblk - 1, b != v.nblk - 1}));
      @(negedge clk);
      chk($sformatf("%s b%0d done_pulse", tag, b), 64'(bus.oMsgDone), 64'(0));
    end
  endtask

  task automatic start_msg(input string tag);
    int n;
    n = 0;
    while (bus.oBusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    chk({tag, " start"}, 64'({bus.oBusy, bus.oReady, bus.oDataValid}), 64'(3'b110));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_msg(tag);
    fork
      drive_msg(v);
      check_msg(v, tag);
    join
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1,  3'd3, 32'h6162_6300, 0,  32'h6162_6380, 1, 32'h0000_0018}; // "abc"
    vecs[1] = '{1,  3'd0, 32'hDEAD_BEEF, 0,  32'h8000_0000, 1, 32'h0000_0000}; // empty
    vecs[2] = '{14, 3'd3, 32'h6161_61FF, 13, 32'h6161_6180, 1, 32'h0000_01B8}; // 55 bytes
    vecs[3] = '{14, 3'd4, P,             14, 32'h8000_0000, 2, 32'h0000_01C0}; // 56 bytes
    vecs[4] = '{16, 3'd4, P,             16, 32'h8000_0000, 2, 32'h0000_0200}; // 64 bytes
    vecs[5] = '{2,  3'd7, 32'h1234_5678, 2,  32'h8000_0000, 1, 32'h0000_0040}; // lb>4 -> 4
    vecs[6] = '{16, 3'd1, 32'h4142_4344, 15, 32'h4180_0000, 2, 32'h0000_01E8}; // 61 bytes
    vecs[7] = '{17, 3'd2, 32'hABCD_EF01, 16, 32'hABCD_8000, 2, 32'h0000_0210}; // 66 bytes

    bus.iStart     = 1'b0;
    bus.iValid     = 1'b0;
    bus.iWord      = '0;
    bus.iLast      = 1'b0;
    bus.iLastBytes = '0;
    bus.iCoreDone  = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset outputs",
        64'({bus.oReady, bus.oDataValid, bus.oData, bus.oWordIdx, bus.oBlockStart,
             bus.oFirstBlock, bus.oLastBlock, bus.oMsgDone, bus.oBusy}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 64'({bus.oBusy, bus.oReady}), 64'(0));

    for (int t = 0; t < 8; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // reset in the middle of a burst aborts the message
    start_msg("rst");
    drive_msg(vecs[0]);
    n = 0;
    while (!(bus.oDataValid && bus.oWordIdx == 4'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst reached idx7", 64'(bus.oWordIdx), 64'(7));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mid-emit", 64'({bus.oDataValid, bus.oBusy, bus.oReady, bus.oData}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "abc_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
